spi_master_simple: RTL and testbench

Single-frame SPI initiator that drives spi_cs, spi_clk and spi_do, and captures spi_di. It is the transmit-side counterpart of the passive SPI capture path. Each accepted word is shifted out MSB first as one 32-bit frame in SPI mode 0, and the 32-bit response is returned. Used as the stimulus and bring-up master for the spiMonitor design; its frames meet the capture path's timing (system clk at least 4x spi_clk, cs framing every 32 bits).

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_clk_gen.sv | 32 +++
 rtl/spi_master_simple.sv | 172 +++++++++++++++++
 tb/tb_spi_master_simple.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and FSM state encoding for the SPI initiator.
package spi_pkg;

  localparam int   SPI_FRAME_BITS = 32;
  localparam logic SPI_CS_ACTIVE  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEAD = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_GAP  = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// Phase timer: counts 0..period_m1_i while enabled and flags the last cycle of each phase.
module spi_clk_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [7:0] period_m1_i,
  output logic       phase_end_o
);

  logic [7:0] cnt_q, cnt_d;

  assign phase_end_o = en_i && (cnt_q == period_m1_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = phase_end_o ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_simple.sv
// SPI mode-0 initiator: one 32-bit MSB-first frame per accepted word, response returned on rx_*.
// The phase timer lives in spi_clk_gen; this module owns the FSM, shift registers and bit counter.
module spi_master_simple
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 8,
  parameter int FRAME_BITS = SPI_FRAME_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [31:0] tx_data,
  output logic        rx_valid,
  output logic [31:0] rx_data,
  output logic        busy,
  output logic        spi_cs,
  output logic        spi_clk,
  output logic        spi_do,
  input  logic        spi_di,
  output logic [2:0]  dbg_state_o
);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_master_simple: CLK_DIV must be 2..255");
  end
  if (CS_GAP < 1 || CS_GAP > 255) begin : g_bad_cs_gap
    $error("spi_master_simple: CS_GAP must be 1..255");
  end
  if (FRAME_BITS != SPI_FRAME_BITS) begin : g_bad_frame
    $error("spi_master_simple: FRAME_BITS is fixed at 32");
  end

  localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_M1   = 8'(CS_GAP - 1);
  localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS);

  spi_state_e  state_q, state_d;
  logic [31:0] tx_sh_q, tx_sh_d;
  logic [31:0] rx_sh_q, rx_sh_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_ready_q, tx_ready_d;
  logic        busy_q, busy_d;
  logic        cs_q, cs_d;
  logic        sclk_q, sclk_d;
  logic        do_q, do_d;
  logic        accept;
  logic        phase_end;

  // Handshake: a word is taken on any clk edge where tx_valid and tx_ready are both high;
  // tx_valid while tx_ready is low is ignored and never queued.
  assign accept = tx_valid && tx_ready_q;

  spi_clk_gen u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .en_i       (state_q != ST_IDLE),
    .clr_i      (accept),
    .period_m1_i((state_q == ST_GAP) ? GAP_M1 : DIV_M1),
    .phase_end_o(phase_end)
  );

  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    rx_valid_d = 1'b0;
    tx_ready_d = 1'b0;
    busy_d     = busy_q;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    do_d       = do_q;
    unique case (state_q)
      ST_IDLE: begin
        tx_ready_d = ~accept;
        if (accept) begin
          state_d   = ST_LEAD;
          tx_sh_d   = {tx_data[30:0], 1'b0};
          rx_sh_d   = '0;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          cs_d      = SPI_CS_ACTIVE;
          sclk_d    = 1'b0;
          do_d      = tx_data[31];
        end
      end
      ST_LEAD: begin
        if (phase_end) begin
          state_d = ST_HIGH;
          sclk_d  = 1'b1;
        end
      end
      ST_HIGH: begin
        if (phase_end) begin
          state_d   = ST_LOW;
          sclk_d    = 1'b0;
          rx_sh_d   = {rx_sh_q[30:0], spi_di};
          bit_cnt_d = bit_cnt_q + 6'd1;
          // After the final bit spi_do simply holds through the hold phase.
          if (bit_cnt_q + 6'd1 < LAST_BIT) begin
            do_d    = tx_sh_q[31];
            tx_sh_d = {tx_sh_q[30:0], 1'b0};
          end
        end
      end
      ST_LOW: begin
        if (phase_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = ST_GAP;
            cs_d       = ~SPI_CS_ACTIVE;
            do_d       = 1'b0;
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
          end else begin
            state_d = ST_HIGH;
            sclk_d  = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (phase_end) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      cs_q       <= ~SPI_CS_ACTIVE;
      sclk_q     <= 1'b0;
      do_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      do_q       <= do_d;
    end
  end

  assign tx_ready    = tx_ready_q;
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign busy        = busy_q;
  assign spi_cs      = cs_q;
  assign spi_clk     = sclk_q;
  assign spi_do      = do_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_master_simple.sv
// Bench for spi_master_simple: scoreboarded frames with loopback or a mode-0 slave model,
// plus frame timing, back-to-back, mid-frame reset and a CLK_DIV=2 instance with a passive capture.
module tb_spi_master_simple;
  import spi_pkg::*;

  localparam int CLK_DIV   = 4;
  localparam int CS_GAP    = 8;
  localparam int CLK_DIV_B = 2;
  localparam int CS_GAP_B  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- DUT A (CLK_DIV=4) ----------------
  logic        tx_valid = 1'b0;
  logic [31:0] tx_data  = '0;
  logic        tx_ready, rx_valid, busy, spi_cs, spi_clk, spi_do, spi_di;
  logic [31:0] rx_data;
  logic [2:0]  dbg_state;

  spi_master_simple #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut_a (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .spi_cs(spi_cs),
    .spi_clk(spi_clk), .spi_do(spi_do), .spi_di(spi_di), .dbg_state_o(dbg_state)
  );

  // ---------------- DUT B (CLK_DIV=2) ----------------
  logic        b_tx_valid = 1'b0;
  logic [31:0] b_tx_data  = '0;
  logic        b_tx_ready, b_rx_valid, b_busy, b_spi_cs, b_spi_clk, b_spi_do, b_spi_di;
  logic [31:0] b_rx_data;
  logic [2:0]  b_dbg_state;

  spi_master_simple #(.CLK_DIV(CLK_DIV_B), .CS_GAP(CS_GAP_B)) dut_b (
    .clk(clk), .rst(rst), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_data(b_tx_data),
    .rx_valid(b_rx_valid), .rx_data(b_rx_data), .busy(b_busy), .spi_cs(b_spi_cs),
    .spi_clk(b_spi_clk), .spi_do(b_spi_do), .spi_di(b_spi_di), .dbg_state_o(b_dbg_state)
  );
  assign b_spi_di = b_spi_do;

  // ---------------- slave model / loopback for A ----------------
  logic        di_mode    = 1'b0;  // 0: loopback, 1: slave returns slave_word
  logic [31:0] slave_word = '0;
  int          sl_idx     = 31;

  assign spi_di = di_mode ? ((sl_idx >= 0) ? slave_word[sl_idx[4:0]] : 1'b0) : spi_do;

  initial forever begin
    @(negedge spi_cs);
    sl_idx = 31;
  end
  initial forever begin
    @(negedge spi_clk);
    if (!spi_cs) sl_idx = sl_idx - 1;
  end

  // passive capture of B's master-out stream
  logic [31:0] cap_w = '0;
  initial forever begin
    @(posedge b_spi_clk or negedge b_spi_cs);
    if (!b_spi_cs && b_spi_clk) cap_w = {cap_w[30:0], b_spi_do};
    else if (!b_spi_cs && !b_spi_clk) cap_w = '0;
  end

  // ---------------- scoreboard ----------------
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mosi_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // rx monitor: every rx_valid pulse must match the oldest outstanding expectation
  initial forever begin
    @(negedge clk);
    if (!rst && rx_valid) begin
      if (exp_q.size() == 0) chk("rx_unexpected", 32'(rx_valid), 32'd0);
      else chk("rx_data", rx_data, exp_q.pop_front());
    end
  end

  // bus monitor: frame length, edge count and master-out word of every completed frame
  int          low_cnt = 0, rise_cnt = 0, high_cnt = 0, last_gap = 0, frame_cnt = 0;
  logic        in_frame = 1'b0, sclk_prev = 1'b0;
  logic [31:0] mosi_w = '0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      in_frame  = 1'b0;
      sclk_prev = 1'b0;
      high_cnt  = 0;
    end else begin
      if (!spi_cs) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          low_cnt  = 0;
          rise_cnt = 0;
          mosi_w   = '0;
          last_gap = high_cnt;
        end
        low_cnt++;
        if (spi_clk && !sclk_prev) begin
          rise_cnt++;
          mosi_w = {mosi_w[30:0], spi_do};
        end
      end else begin
        if (in_frame) begin
          in_frame = 1'b0;
          frame_cnt++;
          chk("cs_low_cycles", low_cnt, CLK_DIV * 65);
          chk("sclk_rises", rise_cnt, 32'd32);
          if (mosi_q.size() == 0) chk("mosi_unexpected", 32'(mosi_q.size()), 32'd1);
          else chk("mosi_word", mosi_w, mosi_q.pop_front());
          high_cnt = 0;
        end
        high_cnt++;
      end
      sclk_prev = spi_clk;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] w, input logic hold, output int t_acc);
    int n;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = w;
    n = 0;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      chk("accept_timeout", 32'(tx_ready), 32'd1);
      tx_valid = 1'b0;
      t_acc    = -1;
      return;
    end
    t_acc = cyc;
    exp_q.push_back(di_mode ? slave_word : w);
    mosi_q.push_back(w);
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
    tx_data = $urandom;
    chk("cs_after_accept", 32'(spi_cs), 32'd0);
    chk("first_do_bit", 32'(spi_do), 32'(w[31]));
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("ready_after_accept", 32'(tx_ready), 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mosi_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", 32'(exp_q.size() + mosi_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t1, t2, n, zeros, f0;
    logic [31:0] w;

    #1;
    do_reset();
    chk("rst_cs", 32'(spi_cs), 32'd1);
    chk("rst_sclk", 32'(spi_clk), 32'd0);
    chk("rst_do", 32'(spi_do), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", rx_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(tx_ready), 32'd1);

    // loopback frame
    di_mode = 1'b0;
    send(32'hA5A5_0F0F, 1'b0, t1);
    drain();

    // slave returns a fixed word; master sends all ones
    di_mode    = 1'b1;
    slave_word = 32'h1234_5678;
    send(32'hFFFF_FFFF, 1'b0, t1);
    zeros = 0;
    n     = 0;
    @(negedge clk);
    while (!spi_cs && n < 1000) begin
      if (!spi_do) zeros++;
      n++;
      @(negedge clk);
    end
    chk("do_const_one", zeros, 32'd0);
    drain();

    // back-to-back with tx_valid held high
    di_mode = 1'b0;
    send(32'h0000_0001, 1'b1, t1);
    send(32'h8000_0000, 1'b0, t2);
    chk("b2b_spacing", t2 - t1, CLK_DIV * 65 + CS_GAP + 2);
    drain();
    chk("cs_gap_min", 32'(last_gap >= CS_GAP), 32'd1);

    // reset at the 10th rising spi_clk edge
    send($urandom, 1'b0, t1);
    repeat (2) @(negedge clk);
    n = 0;
    while (rise_cnt < 10 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_10th_rise", 32'(rise_cnt >= 10), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    mosi_q.delete();
    #1;
    chk("async_rst_cs", 32'(spi_cs), 32'd1);
    chk("async_rst_sclk", 32'(spi_clk), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_rx_data_cleared", rx_data, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_midframe_rst", 32'(tx_ready), 32'd1);
    send(32'hDEAD_BEEF, 1'b0, t1);
    drain();

    // tx_valid pulsed with changing data while busy
    w  = $urandom;
    f0 = frame_cnt;
    send(w, 1'b0, t1);
    repeat (40) begin
      @(negedge clk);
      chk("ready_while_busy", 32'(tx_ready), 32'd0);
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = $urandom;
    end
    tx_valid = 1'b0;
    drain();
    repeat (20) @(negedge clk);
    chk("single_frame", frame_cnt - f0, 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(tx_ready), 32'd1);

    // random words, random return source
    repeat (4) begin
      di_mode    = 1'($urandom_range(0, 1));
      slave_word = $urandom;
      send($urandom, 1'b0, t1);
      drain();
    end

    // instance B: CLK_DIV=2 with passive capture
    @(negedge clk);
    b_tx_valid = 1'b1;
    b_tx_data  = 32'hCAFE_F00D;
    n = 0;
    while (!b_tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b_accept", 32'(b_tx_ready), 32'd1);
    @(posedge clk);
    #1;
    b_tx_valid = 1'b0;
    b_tx_data  = 32'h0;
    n = 0;
    @(negedge clk);
    while (!b_spi_cs && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("b_cs_low_cycles", n, CLK_DIV_B * 65);
    chk("b_captured_mosi", cap_w, 32'hCAFE_F00D);
    chk("b_rx_valid", 32'(b_rx_valid), 32'd1);
    chk("b_rx_data", b_rx_data, 32'hCAFE_F00D);
    repeat (CS_GAP_B + 4) @(negedge clk);
    chk("b_idle_state", 32'(b_dbg_state), 32'(ST_IDLE));
    chk("b_idle_busy", 32'(b_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
